muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer that borrows the shared 32-bit ALU for one add/subtract per cycle instead of instantiating its own adder.
- Sits beside the execute stage. The core stalls while `busy` is high.
- The top level muxes the ALU operand and select inputs to this block whenever `alu_own` is high.

Parameters:
- None. The datapath is fixed at 32 bits to match the shared ALU.

Ports:
- `clk` input 1: clock. All state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request. Sampled only in IDLE.
- `funct` input 3: RV32M funct3 (000 MUL, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
- `rs1` input 32: dividend / multiplicand. Latched at accept.
- `rs2` input 32: divisor / multiplier. Latched at accept.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when `result` is valid.
- `result` output 32: final value. Held until the next accept.
- `alu_own` output 1: high while the block drives the ALU (PREP_A, PREP_B, LOOP, FIX).
- `alu_opdA` output 32: shared ALU operand A.
- `alu_opdB` output 32: shared ALU operand B.
- `alu_op_sel` output 4: shared ALU select. Only the `ADD` and `SUB` codes from header.vh are used.
- `alu_out` input 32: shared ALU result, combinational from the current operands.

Behaviour:
- Reset:
  - state = IDLE; `busy`, `done`, `alu_own` = 0; `result` = 0; all internal registers = 0.
  - `alu_opdA`, `alu_opdB`, `alu_op_sel` = 0 whenever `alu_own` = 0.
  - Reset asserted mid-operation aborts immediately with no `done`.
- States: IDLE, PREP_A, PREP_B, LOOP, FIX, DONE.
- IDLE, `start` = 1, accept:
  - Latch `rs1`, `rs2`, `funct`.
  - DIV/REM go to PREP_A. MUL/MULHU/DIVU/REMU go to LOOP with iteration counter = 0.
  - Unsupported funct (001, 010) goes to DONE with `result` = 0.
- `start` while `busy` is ignored. No queuing.
- PREP_A (signed only): ALU computes |a|. SUB 0 − a if a[31], else ADD 0 + a. The dividend register takes `alu_out`.
- PREP_B (signed only): ALU computes |b| the same way. Record `neg_q` = a[31]^b[31] and `neg_r` = a[31]. Go to LOOP.
- LOOP, multiply (unsigned shift-add, 64-bit {P_hi, P_lo}, P_lo initialised with the multiplier, P_hi = 0):
  - ALU ADD, opdA = P_hi, opdB = P_lo[0] ? multiplicand : 0.
  - carry = (`alu_out` < P_hi) unsigned, computed internally.
  - {P_hi, P_lo} <= {carry, `alu_out`, P_lo} >> 1.
- LOOP, divide (restoring; R = 0, Q = dividend):
  - sh = {R[30:0], Q[31]}, msb = R[31].
  - ALU SUB, opdA = sh, opdB = divisor.
  - If msb or sh >= divisor (unsigned, internal compare): R <= `alu_out`, Q <= {Q[30:0], 1].
  - Otherwise: R <= sh, Q <= {Q[30:0], 0}.
- LOOP exits after exactly 32 iterations:
  - Signed ops go to FIX.
  - Unsigned ops go to DONE, latching `result` = P_lo (MUL), P_hi (MULHU), Q (DIVU) or R (REMU).
- FIX, DIV: ALU negates Q (SUB 0 − Q) if `neg_q` and divisor ≠ 0, else ADD 0 + Q. Go to DONE with that value.
- FIX, REM: ALU negates R if `neg_r`, else ADD 0 + R. Go to DONE with that value.
- DONE: `done` = 1 for exactly one cycle, then IDLE.
- Latency, counted as cycles from the accept edge to the `done`-high cycle: 33 for MUL/MULHU/DIVU/REMU, 36 for DIV/REM, 1 for unsupported.
- Divide by zero falls out of the datapath naturally: Q = 0xFFFFFFFF, R = dividend. No sign fix on Q.
- Overflow 0x80000000 / −1 yields Q = 0x80000000, R = 0 with no special case.

Test Plan:
- MUL 7 × 6 → `done` at cycle 33, `result` = 42. `alu_own` high for exactly 32 cycles.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → `result` = 0xFFFFFFFE. MUL with the same operands → 0x00000001.
- DIVU 100 / 7 → 14. REMU → 2. DIV −7 / 2 → 0xFFFFFFFD at cycle 36. REM → 0xFFFFFFFF.
- DIVU 0x1234 / 0 → 0xFFFFFFFF. REMU → 0x1234. DIV −5 / 0 → 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM → 0.
- `start` pulsed at cycle 10 of a MUL with new operands → ignored; the original result is returned at cycle 33. Unsupported funct 001 → `done` at cycle 1, `result` = 0.
- `rst` asserted at cycle 15 of a DIVU → outputs go to 0 at once, no `done`. A subsequent DIVU 9 / 3 → 3.

Source files
------------

// File: rtl/muldiv_seq.sv
// ============================================================================
// Module      : muldiv_seq
// Description : Iterative RV32M multiply/divide sequencer that time-shares the
//               core's 32-bit ALU for one add/subtract per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        alu_own,
    output logic [31:0] alu_opdA,
    output logic [31:0] alu_opdB,
    output logic [3:0]  alu_op_sel,
    input  logic [31:0] alu_out
);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_PREP_A = 3'd1;
    localparam logic [2:0] c_S_PREP_B = 3'd2;
    localparam logic [2:0] c_S_LOOP   = 3'd3;
    localparam logic [2:0] c_S_FIX    = 3'd4;
    localparam logic [2:0] c_S_DONE   = 3'd5;

    localparam logic [2:0] c_F_MUL   = 3'b000;
    localparam logic [2:0] c_F_MULHU = 3'b011;
    localparam logic [2:0] c_F_DIV   = 3'b100;
    localparam logic [2:0] c_F_DIVU  = 3'b101;
    localparam logic [2:0] c_F_REM   = 3'b110;
    localparam logic [2:0] c_F_REMU  = 3'b111;

    // Shared ALU select codes (ADD/SUB encodings of the core ALU)
    localparam logic [3:0] c_ALU_ADD = 4'b0000;
    localparam logic [3:0] c_ALU_SUB = 4'b1000;

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [2:0]  r_funct;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [4:0]  r_cnt;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_result;

    logic        w_is_mul;
    logic        w_signed;
    logic        w_last;
    logic [31:0] w_sh;
    logic        w_take;
    logic        w_carry;
    logic [31:0] w_hi_nx;
    logic [31:0] w_lo_nx;

    assign w_is_mul = (r_funct == c_F_MUL) || (r_funct == c_F_MULHU);
    assign w_signed = (r_funct == c_F_DIV) || (r_funct == c_F_REM);
    assign w_last   = (r_cnt == 5'd31);
    assign w_sh     = {r_hi[30:0], r_lo[31]};
    assign w_take   = r_hi[31] || (w_sh >= r_b);
    assign w_carry  = (alu_out < r_hi);

    // One loop step: shift-add for multiply, restoring step for divide
    always_comb begin
        if (w_is_mul) begin
            w_hi_nx = {w_carry, alu_out[31:1]};
            w_lo_nx = {alu_out[0], r_lo[31:1]};
        end else begin
            w_hi_nx = w_take ? alu_out : w_sh;
            w_lo_nx = {r_lo[30:0], w_take};
        end
    end

    assign busy    = (r_state != c_S_IDLE);
    assign done    = (r_state == c_S_DONE);
    assign result  = r_result;
    assign alu_own = (r_state == c_S_PREP_A) || (r_state == c_S_PREP_B) ||
                     (r_state == c_S_LOOP)   || (r_state == c_S_FIX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        alu_opdA   = 32'd0;
        alu_opdB   = 32'd0;
        alu_op_sel = c_ALU_ADD;
        case (r_state)
            c_S_IDLE: begin
                if (start) begin
                    case (funct)
                        c_F_MUL, c_F_MULHU, c_F_DIVU, c_F_REMU: w_next = c_S_LOOP;
                        c_F_DIV, c_F_REM:                       w_next = c_S_PREP_A;
                        default:                                w_next = c_S_DONE;
                    endcase
                end
            end
            c_S_PREP_A: begin
                alu_opdB   = r_a;
                alu_op_sel = r_a[31] ? c_ALU_SUB : c_ALU_ADD;
                w_next     = c_S_PREP_B;
            end
            c_S_PREP_B: begin
                alu_opdB   = r_b;
                alu_op_sel = r_b[31] ? c_ALU_SUB : c_ALU_ADD;
                w_next     = c_S_LOOP;
            end
            c_S_LOOP: begin
                if (w_is_mul) begin
                    alu_opdA = r_hi;
                    alu_opdB = r_lo[0] ? r_a : 32'd0;
                end else begin
                    alu_opdA   = w_sh;
                    alu_opdB   = r_b;
                    alu_op_sel = c_ALU_SUB;
                end
                if (w_last) w_next = w_signed ? c_S_FIX : c_S_DONE;
            end
            c_S_FIX: begin
                // A zero divisor leaves the all-ones quotient unsigned
                if (r_funct == c_F_DIV) begin
                    alu_opdB   = r_lo;
                    alu_op_sel = (r_neg_q && (r_b != 32'd0)) ? c_ALU_SUB : c_ALU_ADD;
                end else begin
                    alu_opdB   = r_hi;
                    alu_op_sel = r_neg_r ? c_ALU_SUB : c_ALU_ADD;
                end
                w_next = c_S_DONE;
            end
            c_S_DONE: w_next = c_S_IDLE;
            default:  w_next = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_funct  <= 3'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_cnt    <= 5'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= 32'd0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_funct <= funct;
                        r_a     <= rs1;
                        r_b     <= rs2;
                        r_hi    <= 32'd0;
                        r_lo    <= ((funct == c_F_MUL) || (funct == c_F_MULHU)) ? rs2 : rs1;
                        r_cnt   <= 5'd0;
                        r_neg_q <= 1'b0;
                        r_neg_r <= 1'b0;
                        if ((funct == 3'b001) || (funct == 3'b010)) r_result <= 32'd0;
                    end
                end
                c_S_PREP_A: r_lo <= alu_out;
                c_S_PREP_B: begin
                    r_b     <= alu_out;
                    r_neg_q <= r_a[31] ^ r_b[31];
                    r_neg_r <= r_a[31];
                end
                c_S_LOOP: begin
                    r_hi  <= w_hi_nx;
                    r_lo  <= w_lo_nx;
                    r_cnt <= r_cnt + 5'd1;
                    if (w_last && !w_signed) begin
                        case (r_funct)
                            c_F_MUL:   r_result <= w_lo_nx;
                            c_F_MULHU: r_result <= w_hi_nx;
                            c_F_DIVU:  r_result <= w_lo_nx;
                            default:   r_result <= w_hi_nx;
                        endcase
                    end
                end
                c_S_FIX: r_result <= alu_out;
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
// ============================================================================
// Module      : tb_muldiv_seq
// Description : Scoreboard bench for muldiv_seq with a behavioural shared ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_muldiv_seq;

    localparam logic [3:0] c_ALU_SUB = 4'b1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct = 3'd0;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        alu_own;
    logic [31:0] alu_opdA;
    logic [31:0] alu_opdB;
    logic [3:0]  alu_op_sel;
    logic [31:0] alu_out;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    muldiv_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .funct      (funct),
        .rs1        (rs1),
        .rs2        (rs2),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .alu_own    (alu_own),
        .alu_opdA   (alu_opdA),
        .alu_opdB   (alu_opdB),
        .alu_op_sel (alu_op_sel),
        .alu_out    (alu_out)
    );

    assign alu_out = (alu_op_sel == c_ALU_SUB) ? (alu_opdA - alu_opdB) : (alu_opdA + alu_opdB);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare each done pulse against the oldest expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: result=%h at cycle %0d, nothing expected", result, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (result !== e.res || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL result: got %h at cycle %0d, expected %h at cycle %0d",
                             result, cyc, e.res, e.cyc);
                end
            end
        end
        if (!rst && !alu_own) begin
            checks++;
            if (alu_opdA !== 32'd0 || alu_opdB !== 32'd0 || alu_op_sel !== 4'd0) begin
                errors++;
                $display("FAIL alu_idle: opdA=%h opdB=%h sel=%h, expected all zero",
                         alu_opdA, alu_opdB, alu_op_sel);
            end
        end
    end

    task automatic wait_done(output int own);
        int n;
        n   = 0;
        own = 0;
        while (!done && n < 100) begin
            if (alu_own) own++;
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: done not seen within 100 cycles, got 0 expected 1");
        end
    endtask

    task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input int exp_own);
        int own;
        @(negedge clk);
        start = 1'b1;
        funct = f;
        rs1   = a;
        rs2   = b;
        q.push_back('{res: exp, cyc: cyc + lat});
        @(negedge clk);
        start = 1'b0;
        wait_done(own);
        if (exp_own >= 0) begin
            checks++;
            if (own != exp_own) begin
                errors++;
                $display("FAIL alu_own_cycles: got %0d expected %0d", own, exp_own);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || result !== exp) begin
            errors++;
            $display("FAIL hold: busy=%b result=%h, expected busy=0 result=%h", busy, result, exp);
        end
    endtask

    initial begin
        int own;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || alu_own !== 1'b0 || result !== 32'd0 ||
            alu_opdA !== 32'd0 || alu_opdB !== 32'd0 || alu_op_sel !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b own=%b result=%h, expected all zero",
                     busy, done, alu_own, result);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run(3'b000, 32'd7,        32'd6,        32'd42,         33, 32);
        run(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,   33, -1);
        run(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,   33, -1);
        run(3'b101, 32'd100,      32'd7,        32'd14,         33, -1);
        run(3'b111, 32'd100,      32'd7,        32'd2,          33, -1);
        run(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD,   36, 35);
        run(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF,   36, -1);
        run(3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD,   36, -1);
        run(3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001,   36, -1);
        run(3'b101, 32'h1234,     32'd0,        32'hFFFFFFFF,   33, -1);
        run(3'b111, 32'h1234,     32'd0,        32'h00001234,   33, -1);
        run(3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF,   36, -1);
        run(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,   36, -1);
        run(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000,   36, -1);
        run(3'b001, 32'd55,       32'd66,       32'h00000000,   1,  0);
        run(3'b010, 32'd55,       32'd66,       32'h00000000,   1,  0);

        // start during a busy multiply must be ignored
        @(negedge clk);
        start = 1'b1; funct = 3'b000; rs1 = 32'd3; rs2 = 32'd5;
        q.push_back('{res: 32'd15, cyc: cyc + 33});
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        start = 1'b1; rs1 = 32'd100; rs2 = 32'd100;
        @(negedge clk);
        start = 1'b0;
        wait_done(own);
        repeat (3) @(negedge clk);

        // reset mid-divide aborts with no done
        run(3'b101, 32'd50, 32'd5, 32'd10, 33, -1);
        @(negedge clk);
        start = 1'b1; funct = 3'b101; rs1 = 32'd1000; rs2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || alu_own !== 1'b0 || result !== 32'd0 ||
            alu_opdA !== 32'd0 || alu_opdB !== 32'd0) begin
            errors++;
            $display("FAIL abort: busy=%b done=%b own=%b result=%h, expected all zero",
                     busy, done, alu_own, result);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        run(3'b101, 32'd9, 32'd3, 32'd3, 33, -1);

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
